// File: rtl/cnu10_row_sequencer.sv
// rtl/cnu10_row_sequencer.sv - streams check-node rows into a 2-wide CNU and collects its results
module cnu10_row_sequencer #(
    parameter int CN_DEGREE        = 10,
    parameter int QUAN_SIZE        = 4,
    parameter int ROW_SPLIT_FACTOR = 5,
    parameter int OUT_DEPTH        = 3
) (
    input  logic                           sys_clk,
    input  logic                           rst,
    input  logic [CN_DEGREE*QUAN_SIZE-1:0] in_v2c,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [QUAN_SIZE-1:0]           v2c_0,
    output logic [QUAN_SIZE-1:0]           v2c_1,
    output logic                           first_comp,
    input  logic [QUAN_SIZE-1:0]           c2v_0,
    input  logic [QUAN_SIZE-1:0]           c2v_1,
    output logic [CN_DEGREE*QUAN_SIZE-1:0] out_c2v,
    output logic                           out_valid,
    input  logic                           out_ready
);
    localparam int ROW_W  = CN_DEGREE * QUAN_SIZE;
    localparam int PAIR_W = 2 * QUAN_SIZE;
    localparam int CNT_W  = (ROW_SPLIT_FACTOR > 1) ? $clog2(ROW_SPLIT_FACTOR) : 1;
    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int FCNT_W = $clog2(OUT_DEPTH + 1);
    localparam int CMT_W  = FCNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROW_SPLIT_FACTOR - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic                r_pending, w_pending_next;
    logic [1:0]          r_in_flight;
    logic [ROW_W-1:0]    r_row;
    logic [ROW_W-1:0]    r_stage, w_stage_next;
    logic [ROW_W-1:0]    r_mem [OUT_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [FCNT_W-1:0]   r_count;
    logic                w_active, w_slot_end, w_accept, w_push, w_pop;
    logic [CMT_W-1:0]    w_committed;

    assign w_active   = (r_state != S_IDLE);
    assign w_slot_end = w_active && (r_cnt == LAST_CNT);
    assign w_pop      = out_valid && out_ready;
    assign w_push     = w_slot_end && r_pending;

    // Reserve FIFO space for every row already accepted so the CNU never stalls on a full FIFO.
    assign w_committed = CMT_W'(r_count) - CMT_W'(w_pop) + CMT_W'(r_in_flight);
    assign in_ready    = !rst && (!w_active || w_slot_end) && (w_committed < CMT_W'(OUT_DEPTH));
    assign w_accept    = in_valid && in_ready;

    assign out_valid = (r_count != '0);
    assign out_c2v   = r_mem[r_rd_ptr];

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_pending_next = r_pending;
        v2c_0          = '0;
        v2c_1          = '0;
        first_comp     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_STREAM;
                    w_cnt_next   = '0;
                end
            end
            S_STREAM, S_FLUSH: begin
                if (r_state == S_STREAM) begin
                    v2c_0 = r_row[PAIR_W*r_cnt +: QUAN_SIZE];
                    v2c_1 = r_row[PAIR_W*r_cnt + QUAN_SIZE +: QUAN_SIZE];
                end
                first_comp = (r_cnt == '0);
                if (r_cnt == LAST_CNT) begin
                    w_cnt_next     = '0;
                    w_pending_next = (r_state == S_STREAM);
                    if (w_accept)
                        w_state_next = S_STREAM;
                    else if (r_state == S_STREAM)
                        w_state_next = S_FLUSH;
                    else
                        w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Staging row with the current CNU pair merged in; the last pair goes straight into the FIFO.
    always_comb begin
        w_stage_next = r_stage;
        for (int k = 0; k < ROW_SPLIT_FACTOR; k++) begin
            if (r_cnt == CNT_W'(k))
                w_stage_next[PAIR_W*k +: PAIR_W] = {c2v_1, c2v_0};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pending   <= 1'b0;
            r_in_flight <= '0;
            r_row       <= '0;
            r_stage     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_pending   <= w_pending_next;
            r_in_flight <= r_in_flight + 2'(w_accept) - 2'(w_push);
            if (w_accept)
                r_row <= in_v2c;
            if (w_active && r_pending)
                r_stage <= w_stage_next;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_stage_next;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + FCNT_W'(w_push) - FCNT_W'(w_pop);
        end
    end
endmodule

// File: tb/tb_cnu10_row_sequencer.sv
// tb/tb_cnu10_row_sequencer.sv - directed self-checking bench for cnu10_row_sequencer
module tb_cnu10_row_sequencer;
    localparam int CN  = 10;
    localparam int Q   = 4;
    localparam int RSF = 5;
    localparam int OD  = 3;
    localparam int W   = CN * Q;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_v2c = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [Q-1:0]  v2c_0, v2c_1, c2v_0, c2v_1;
    logic          first_comp;
    logic [W-1:0]  out_c2v;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    logic cnu_const = 1'b0;
    logic [2*Q-1:0] pipe [RSF];
    logic [W-1:0] rows [4];

    cnu10_row_sequencer #(.CN_DEGREE(CN), .QUAN_SIZE(Q), .ROW_SPLIT_FACTOR(RSF), .OUT_DEPTH(OD)) dut (
        .sys_clk(sys_clk), .rst(rst), .in_v2c(in_v2c), .in_valid(in_valid), .in_ready(in_ready),
        .v2c_0(v2c_0), .v2c_1(v2c_1), .first_comp(first_comp), .c2v_0(c2v_0), .c2v_1(c2v_1),
        .out_c2v(out_c2v), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 sys_clk = ~sys_clk;

    // CNU stand-in: echoes each pair RSF cycles later, or returns fixed sign/magnitude codes.
    always @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < RSF; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {v2c_1, v2c_0};
            for (int i = 1; i < RSF; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign c2v_0 = cnu_const ? 4'hF : pipe[RSF-1][Q-1:0];
    assign c2v_1 = cnu_const ? 4'h8 : pipe[RSF-1][2*Q-1:Q];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_v2c = '0;
        next_cycle();
        #2;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_v2c", 64'({v2c_1, v2c_0}), 64'd0);
        check_eq("rst_first_comp", 64'(first_comp), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_c2v", 64'(out_c2v), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready", 64'(in_ready), 64'd1);
        next_cycle();
    endtask

    task automatic run_single(input logic [W-1:0] row, input logic [W-1:0] exp_out, input string tag);
        logic [2*Q-1:0] exp_pair;
        for (int c = 0; c <= 14; c++) begin
            in_valid = (c == 0); in_v2c = row; out_ready = 1'b1;
            #2;
            if (c == 0) check_eq({tag, "_ready0"}, 64'(in_ready), 64'd1);
            check_eq({tag, "_fc"}, 64'(first_comp), 64'(c == 1 || c == 6));
            exp_pair = '0;
            if (c >= 1 && c <= 5) exp_pair = row[2*Q*(c-1) +: 2*Q];
            check_eq({tag, "_pair"}, 64'({v2c_1, v2c_0}), 64'(exp_pair));
            check_eq({tag, "_ovalid"}, 64'(out_valid), 64'(c == 11));
            if (c == 11) check_eq({tag, "_data"}, 64'(out_c2v), 64'(exp_out));
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int idx, nout;
        int acc_cyc [$];
        rows[0] = 40'h13579BDF02;
        rows[1] = 40'hFEDCBA9876;
        rows[2] = 40'h0F1E2D3C4B;
        rows[3] = 40'hA5C3E18642;

        // Single row with message i = i
        do_reset();
        run_single(40'h9876543210, 40'h9876543210, "single");

        // Back-to-back rows
        do_reset();
        idx = 0; nout = 0; acc_cyc.delete();
        for (int c = 0; c <= 30; c++) begin
            in_valid = (idx < 4); in_v2c = rows[(idx < 4) ? idx : 0]; out_ready = 1'b1;
            #2;
            if (in_valid && in_ready) begin acc_cyc.push_back(c); idx++; end
            check_eq("b2b_fc", 64'(first_comp), 64'(c >= 1 && c <= 21 && (c - 1) % 5 == 0));
            if (c >= 21 && c <= 25) check_eq("b2b_flush_pair", 64'({v2c_1, v2c_0}), 64'd0);
            check_eq("b2b_ovalid", 64'(out_valid), 64'(c == 11 || c == 16 || c == 21 || c == 26));
            if (out_valid && nout < 4) begin
                check_eq("b2b_data", 64'(out_c2v), 64'(rows[nout]));
                nout++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        check_eq("b2b_accepts", 64'(acc_cyc.size()), 64'd4);
        for (int i = 0; i < acc_cyc.size() && i < 4; i++)
            check_eq("b2b_acc_cycle", 64'(acc_cyc[i]), 64'(5 * i));

        // Backpressure: out_ready low, in_valid held
        do_reset();
        idx = 0;
        for (int c = 0; c <= 24; c++) begin
            in_valid = 1'b1; in_v2c = rows[(idx < 4) ? idx : 0]; out_ready = 1'b0;
            #2;
            check_eq("bp_in_ready", 64'(in_ready), 64'(c == 0 || c == 5 || c == 10));
            if (in_valid && in_ready) idx++;
            check_eq("bp_fc", 64'(first_comp), 64'(c >= 1 && c <= 16 && (c - 1) % 5 == 0));
            next_cycle();
        end
        check_eq("bp_accepts", 64'(idx), 64'd3);
        in_valid = 1'b0; out_ready = 1'b1;
        #2;
        check_eq("bp_pop_valid", 64'(out_valid), 64'd1);
        check_eq("bp_pop_a", 64'(out_c2v), 64'(rows[0]));
        next_cycle();
        out_ready = 1'b0;
        #2;
        check_eq("bp_reenable", 64'(in_ready), 64'd1);
        check_eq("bp_head_b", 64'(out_c2v), 64'(rows[1]));
        out_ready = 1'b1;
        next_cycle();
        #2;
        check_eq("bp_head_c", 64'(out_c2v), 64'(rows[2]));
        next_cycle();
        #2;
        check_eq("bp_empty", 64'(out_valid), 64'd0);
        next_cycle();

        // Row offered during flush
        do_reset();
        idx = 0; nout = 0; acc_cyc.delete();
        for (int c = 0; c <= 27; c++) begin
            in_valid = (c == 0) || (c >= 7 && idx < 2);
            in_v2c = (c == 0) ? rows[2] : rows[3];
            out_ready = 1'b1;
            #2;
            if (c >= 7 && c <= 10) check_eq("rdf_in_ready", 64'(in_ready), 64'(c == 10));
            if (in_valid && in_ready) begin acc_cyc.push_back(c); idx++; end
            if (c == 11) begin
                check_eq("rdf_fc11", 64'(first_comp), 64'd1);
                check_eq("rdf_pair11", 64'({v2c_1, v2c_0}), 64'(rows[3][2*Q-1:0]));
            end
            check_eq("rdf_ovalid", 64'(out_valid), 64'(c == 11 || c == 21));
            if (c == 11) check_eq("rdf_data0", 64'(out_c2v), 64'(rows[2]));
            if (c == 21) check_eq("rdf_data1", 64'(out_c2v), 64'(rows[3]));
            next_cycle();
        end
        in_valid = 1'b0;
        check_eq("rdf_accepts", 64'(acc_cyc.size()), 64'd2);
        if (acc_cyc.size() == 2) check_eq("rdf_acc_cycle", 64'(acc_cyc[1]), 64'd10);

        // Reset mid-stream
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            in_valid = (c == 0); in_v2c = rows[1]; out_ready = 1'b1;
            if (c == 3) rst = 1'b1;
            #2;
            if (c == 3) check_eq("mrst_in_ready", 64'(in_ready), 64'd0);
            next_cycle();
        end
        rst = 1'b0; in_valid = 1'b0;
        #2;
        check_eq("mrst_pair", 64'({v2c_1, v2c_0}), 64'd0);
        check_eq("mrst_fc", 64'(first_comp), 64'd0);
        check_eq("mrst_out_c2v", 64'(out_c2v), 64'd0);
        check_eq("mrst_in_ready_rel", 64'(in_ready), 64'd1);
        for (int c = 4; c <= 20; c++) begin
            #0;
            check_eq("mrst_no_out", 64'(out_valid), 64'd0);
            next_cycle();
            #2;
        end
        next_cycle();
        run_single(rows[0], rows[0], "after_rst");

        // Sign/magnitude placement
        do_reset();
        cnu_const = 1'b1;
        run_single(rows[3], 40'h8F8F8F8F8F, "signmag");
        for (int c = 0; c < 6; c++) begin
            #2;
            check_eq("signmag_no_flush_capture", 64'(out_valid), 64'd0);
            next_cycle();
        end
        cnu_const = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cnu10_row_sequencer.md
# cnu10_row_sequencer

Row sequencer wrapped around the 10-input partial check-node unit in the layered decoder. It accepts one full check-node row of 10 variable-to-check messages per handshake and streams them into the CNU two per cycle over `ROW_SPLIT_FACTOR` cycles, pulsing `first_comp` on the first pair. It collects the check-to-variable messages the CNU returns during the following row slot. It inserts an all-zero flush row whenever the input runs dry, and buffers finished rows in a small output FIFO with valid/ready.

## Interface
Parameters:
- `CN_DEGREE`, default 10: messages per row.
- `QUAN_SIZE`, default 4: message width, sign in the MSB.
- `ROW_SPLIT_FACTOR`, default 5: cycles per row. `CN_DEGREE/ROW_SPLIT_FACTOR` must equal 2.
- `OUT_DEPTH`, default 3: output FIFO depth in rows.

Ports:
- `sys_clk`, in, 1: the single clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_v2c`, in, `CN_DEGREE*QUAN_SIZE`: message i occupies bits `[QUAN_SIZE*i +: QUAN_SIZE]`.
- `in_valid`, in, 1: a row is offered.
- `in_ready`, out, 1: the row is accepted in a cycle where `in_valid & in_ready`.
- `v2c_0`, out, `QUAN_SIZE`: even message of the current pair, driven to the CNU.
- `v2c_1`, out, `QUAN_SIZE`: odd message of the current pair, driven to the CNU.
- `first_comp`, out, 1: high on pair 0 of every streamed row, real or flush.
- `c2v_0`, in, `QUAN_SIZE`: CNU output for the even message.
- `c2v_1`, in, `QUAN_SIZE`: CNU output for the odd message.
- `out_c2v`, out, `CN_DEGREE*QUAN_SIZE`: FIFO head row, packed the same way as `in_v2c`.
- `out_valid`, out, 1: the FIFO is non-empty.
- `out_ready`, in, 1: pops the head row when `out_valid` is also high.

## Operation
**Downstream contract.**
- The CNU returns row r, pair k, exactly `ROW_SPLIT_FACTOR` cycles after that pair was driven.
- This is only valid if row r+1 begins streaming in the cycle immediately after row r's last pair.
- Once a row starts, every subsequent slot must therefore be filled with no gaps until a flush has drained it.

**Row register and pair order.**
- The row register is loaded on acceptance.
- Pair k (k = 0..4) drives `v2c_0` = message 2k and `v2c_1` = message 2k+1.
- `cnt` counts pairs 0..4 and wraps to 0 after 4.

**FSM states: IDLE, STREAM, FLUSH.**
- IDLE: `v2c_*` = 0 and `first_comp` = 0. On accept, go to STREAM with `cnt`=0.
- STREAM: drive pair `cnt` from the row register; `first_comp` = (`cnt`==0). At `cnt`==4: go to STREAM if a row is accepted this cycle, else go to FLUSH.
- FLUSH: drive zeros; `first_comp` = (`cnt`==0). At `cnt`==4: go to STREAM if a row is accepted, else go to IDLE.
- `in_ready` is high only in IDLE, or at `cnt`==4 in STREAM or FLUSH, and only when the admission rule below holds.
- A started FLUSH is never aborted. A row offered mid-flush waits until the FLUSH `cnt`==4 cycle.

**Capture.**
- A flag `pending` marks a real row resident in the CNU.
- Whenever a row slot starts (STREAM or FLUSH) with `pending`=1, `c2v_0`/`c2v_1` are written at pair slot `cnt` into slots 2`cnt` and 2`cnt`+1 of a staging row.
- At the slot's `cnt`==4 edge the staging row is pushed into the FIFO.
- `pending` becomes 1 at the end of a STREAM slot and 0 at the end of a FLUSH slot.
- Flush-row CNU outputs are never captured.

**Admission.**
- `committed` = `fifo_count` − (`out_valid & out_ready`) + `in_flight`.
- `in_flight` (0..2) counts accepted real rows not yet pushed into the FIFO.
- Accept is allowed iff `committed` < `OUT_DEPTH`. This guarantees every mandatory capture finds FIFO space, so a push never overflows.
- Push and pop in the same cycle are both performed, and the count is unchanged.

## Timing
Reset values, cycle after `rst` is sampled high:
- State IDLE, `cnt`=0, `pending`=0, `in_flight`=0, FIFO empty.
- `v2c_0`=0, `v2c_1`=0, `first_comp`=0, `out_valid`=0, `out_c2v`=0 (FIFO storage is cleared).
- `in_ready`=0 while `rst` is high and 1 in the first cycle after it is released.

Behaviour and latency:
- Reset mid-row abandons all in-flight rows. The CNU is reset by the same event, externally.
- Single row accepted in cycle 0: streams cycles 1–5 (`first_comp` in cycle 1), flush cycles 6–10, `out_valid` high in cycle 11.
- Throughput with `out_ready` held high: one row per 5 cycles. Acceptances land at cycles 0, 5, 10, …
- Row r's `out_valid` comes 11 cycles after its acceptance, whether it is followed by a real row or a flush.
- `in_ready` and `out_valid` are combinational from registered state plus `in_valid`-independent terms. `in_ready` never depends on `in_valid`.

## Test plan
- **Single row.** After reset, offer row with message i = i (4'h0..4'h9); CNU model echoes with a 5-cycle delay. Expect: accept at cycle 0; `first_comp` at cycles 1 and 6; `v2c_0`/`v2c_1` = 0/1, 2/3, …, 8/9 in cycles 1–5 and 0/0 in cycles 6–10; `out_valid` at 11 with `out_c2v` = input row.
- **Back-to-back.** Offer 4 rows with `out_ready`=1. Expect accepts at cycles 0, 5, 10, 15, no gap in `first_comp` (every 5 cycles), one flush at cycles 21–25, outputs at cycles 11, 16, 21, 26 in order.
- **Backpressure.** Hold `out_ready`=0 and `in_valid`=1. Expect exactly 3 accepts (cycles 0, 5, 10); flush at 16–20; then `in_ready` stuck at 0 with `fifo_count`=3. Pulsing `out_ready` for 1 cycle pops row A and re-enables `in_ready` in the next cycle.
- **Row during flush.** Accept at cycle 0, then offer a row at cycle 7. Expect `in_ready`=0 at cycles 7–9 and accept at cycle 10, STREAM 11–15, first output at cycle 11.
- **Reset mid-stream.** Assert `rst` at cycle 3 of a row. Expect all outputs at reset values, no `out_valid` ever for that row, and a clean new single-row run afterwards.
- **Sign/magnitude passthrough.** CNU model returns 4'hF/4'h8 per pair. Expect exact bit placement in slots 2k and 2k+1 of `out_c2v`.
